// File: rtl/traffic_display.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_display
//  Purpose  : Lamp driver, blinking yellow, 2-digit multiplexed seven-segment
//             countdown and sticky illegal-phase fault flag.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_display #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 8
) (
    input  logic       div_clk,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] value,
    output logic       led_g,
    output logic       led_y,
    output logic       led_r,
    output logic [6:0] seg,
    output logic [1:0] digit_sel,
    output logic       fault
);

    localparam int c_SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);

    localparam logic [1:0] c_GREEN   = 2'd0;
    localparam logic [1:0] c_YELLO   = 2'd1;
    localparam logic [1:0] c_RED     = 2'd2;
    localparam logic [1:0] c_ILLEGAL = 2'd3;
    localparam logic [1:0] c_SEL_TENS = 2'b10;
    localparam logic [6:0] c_SEG_BLANK = 7'h00;
    localparam logic [6:0] c_SEG_DASH  = 7'h40;
    localparam logic [6:0] c_SEG_ONE   = 7'h06;

    logic [1:0]           r_status_q;
    logic [3:0]           r_value_q;
    logic [c_SCAN_W-1:0]  r_scan_cnt;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_phase;

    logic       w_restart;
    logic       w_blink_wrap;
    logic       w_scan_wrap;
    logic [1:0] w_sel_n;
    logic       w_fault_n;
    logic       w_tens;
    logic [3:0] w_ones;
    logic [6:0] w_ones_seg;
    logic [6:0] w_seg_n;
    logic       w_g_n;
    logic       w_y_n;
    logic       w_r_n;

    assign w_restart    = (status != r_status_q);
    assign w_blink_wrap = (r_blink_cnt == c_BLINK_LAST);
    assign w_scan_wrap  = (r_scan_cnt == c_SCAN_LAST);
    // One-hot select flips between 01 and 10 by simple inversion.
    assign w_sel_n      = w_scan_wrap ? ~digit_sel : digit_sel;
    assign w_fault_n    = fault | (r_status_q == c_ILLEGAL);
    assign w_tens       = (r_value_q >= 4'd10);
    assign w_ones       = w_tens ? (r_value_q - 4'd10) : r_value_q;

    always_comb begin
        w_ones_seg = c_SEG_BLANK;
        case (w_ones)
            4'd0:    w_ones_seg = 7'h3F;
            4'd1:    w_ones_seg = 7'h06;
            4'd2:    w_ones_seg = 7'h5B;
            4'd3:    w_ones_seg = 7'h4F;
            4'd4:    w_ones_seg = 7'h66;
            4'd5:    w_ones_seg = 7'h6D;
            4'd6:    w_ones_seg = 7'h7D;
            4'd7:    w_ones_seg = 7'h07;
            4'd8:    w_ones_seg = 7'h7F;
            4'd9:    w_ones_seg = 7'h6F;
            default: w_ones_seg = c_SEG_BLANK;
        endcase
    end

    // Segment pattern follows the select value being registered alongside it.
    always_comb begin
        w_seg_n = w_ones_seg;
        if (w_fault_n) begin
            w_seg_n = c_SEG_DASH;
        end else if (w_sel_n == c_SEL_TENS) begin
            w_seg_n = w_tens ? c_SEG_ONE : c_SEG_BLANK;
        end
    end

    always_comb begin
        w_g_n = 1'b0;
        w_y_n = 1'b0;
        w_r_n = 1'b0;
        if (w_fault_n) begin
            w_r_n = r_blink_phase;
        end else begin
            case (r_status_q)
                c_GREEN: w_g_n = 1'b1;
                c_YELLO: w_y_n = r_blink_phase;
                c_RED:   w_r_n = 1'b1;
                default: w_r_n = 1'b0;
            endcase
        end
    end

    always_ff @(posedge div_clk) begin
        if (reset) begin
            r_status_q    <= c_GREEN;
            r_value_q     <= 4'd0;
            r_scan_cnt    <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
            led_g         <= 1'b0;
            led_y         <= 1'b0;
            led_r         <= 1'b0;
            seg           <= c_SEG_BLANK;
            digit_sel     <= 2'b01;
            fault         <= 1'b0;
        end else begin
            r_status_q <= status;
            r_value_q  <= value;
            r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
            // A phase change restarts the blink lit, overriding the wrap toggle.
            if (w_restart) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b1;
            end else if (w_blink_wrap) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 1'b1;
            end
            led_g     <= w_g_n;
            led_y     <= w_y_n;
            led_r     <= w_r_n;
            seg       <= w_seg_n;
            digit_sel <= w_sel_n;
            fault     <= w_fault_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_display
//  Purpose  : Self-checking bench for traffic_display: vector table, directed
//             blink/restart/fault sequences and random stimulus vs a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    logic       div_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [1:0] status  = 2'd0;
    logic [3:0] value   = 4'd0;
    logic       led_g, led_y, led_r, fault;
    logic [6:0] seg;
    logic [1:0] digit_sel;

    int errors = 0;
    int checks = 0;

    traffic_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .div_clk   (div_clk),
        .reset     (reset),
        .status    (status),
        .value     (value),
        .led_g     (led_g),
        .led_y     (led_y),
        .led_r     (led_r),
        .seg       (seg),
        .digit_sel (digit_sel),
        .fault     (fault)
    );

    always #5 div_clk = ~div_clk;

    // Reference model: time-based view (edges since reset, edge of last restart).
    int          m_n;
    int          m_restart;
    logic [1:0]  m_sq;
    logic [3:0]  m_vq;
    bit          m_flt;
    logic [12:0] exp_out;

    function automatic logic [6:0] digit_code(input int d);
        logic [6:0] codes [10];
        codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return codes[d];
    endfunction

    function automatic logic [12:0] dut_out();
        return {led_g, led_y, led_r, seg, digit_sel, fault};
    endfunction

    task automatic model_step(input bit rst, input logic [1:0] s, input logic [3:0] v);
        bit         ph, fo;
        logic       g, y, r;
        logic [1:0] sel;
        logic [6:0] sg;
        if (rst) begin
            exp_out   = {3'b000, 7'h00, 2'b01, 1'b0};
            m_n       = 0;
            m_restart = 0;
            m_sq      = 2'd0;
            m_vq      = 4'd0;
            m_flt     = 1'b0;
        end else begin
            m_n++;
            ph = (((m_n - 1 - m_restart) / BLINK_DIV) % 2) == 0;
            fo = m_flt || (m_sq == 2'd3);
            g = 1'b0; y = 1'b0; r = 1'b0;
            if (fo)               r = ph;
            else if (m_sq == 2'd0) g = 1'b1;
            else if (m_sq == 2'd1) y = ph;
            else if (m_sq == 2'd2) r = 1'b1;
            sel = (((m_n / SCAN_DIV) % 2) == 1) ? 2'b10 : 2'b01;
            if (fo)                sg = 7'h40;
            else if (sel == 2'b10) sg = (m_vq >= 4'd10) ? digit_code(1) : 7'h00;
            else                   sg = digit_code(int'(m_vq) % 10);
            exp_out = {g, y, r, sg, sel, fo};
            if (s != m_sq) m_restart = m_n;
            m_flt = fo;
            m_sq  = s;
            m_vq  = v;
        end
    endtask

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input bit rst, input logic [1:0] s, input logic [3:0] v);
        reset  = rst;
        status = s;
        value  = v;
        @(posedge div_clk);
        model_step(rst, s, v);
        #1;
        check("model", dut_out(), exp_out);
    endtask

    typedef struct {
        bit          rst;
        logic [1:0]  s;
        logic [3:0]  v;
        logic [12:0] exp;   // {g,y,r,seg,digit_sel,fault}
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 4'd0,  {3'b000, 7'h00, 2'b01, 1'b0}};
        tbl[1]  = '{1'b1, 2'd0, 4'd0,  {3'b000, 7'h00, 2'b01, 1'b0}};
        tbl[2]  = '{1'b0, 2'd0, 4'd15, {3'b100, 7'h3F, 2'b01, 1'b0}};
        tbl[3]  = '{1'b0, 2'd1, 4'd15, {3'b100, 7'h6D, 2'b01, 1'b0}};
        tbl[4]  = '{1'b0, 2'd1, 4'd15, {3'b010, 7'h6D, 2'b01, 1'b0}};
        tbl[5]  = '{1'b0, 2'd3, 4'd12, {3'b010, 7'h06, 2'b10, 1'b0}};
        tbl[6]  = '{1'b0, 2'd2, 4'd12, {3'b001, 7'h40, 2'b10, 1'b1}};
        tbl[7]  = '{1'b0, 2'd2, 4'd12, {3'b001, 7'h40, 2'b10, 1'b1}};
        tbl[8]  = '{1'b1, 2'd2, 4'd12, {3'b000, 7'h00, 2'b01, 1'b0}};
        tbl[9]  = '{1'b0, 2'd2, 4'd7,  {3'b100, 7'h3F, 2'b01, 1'b0}};
        tbl[10] = '{1'b0, 2'd2, 4'd7,  {3'b001, 7'h07, 2'b01, 1'b0}};

        for (int i = 0; i < 11; i++) begin
            tick(tbl[i].rst, tbl[i].s, tbl[i].v);
            check($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
        end

        // Yellow blink: lit 8, dark 8, lit again.
        tick(1'b1, 2'd0, 4'd5);
        repeat (3) tick(1'b0, 2'd0, 4'd5);
        for (int j = 0; j < 18; j++) begin
            tick(1'b0, 2'd1, 4'd5);
            if (j >= 1)
                check($sformatf("blink[%0d]", j), {11'd0, led_g, led_y},
                      {11'd0, 1'b0, ((j <= 8) || (j >= 17))});
        end

        // Dark yellow, then 1->2->1: one red cycle, then lit yellow at once.
        tick(1'b1, 2'd0, 4'd5);
        tick(1'b0, 2'd0, 4'd5);
        for (int j = 0; j < 13; j++) begin
            tick(1'b0, (j == 10) ? 2'd2 : 2'd1, 4'd5);
            if (j == 10) check("restart_dark", {11'd0, led_y, led_r}, 13'b00);
            if (j == 11) check("restart_red",  {11'd0, led_y, led_r}, 13'b01);
            if (j == 12) check("restart_lit",  {11'd0, led_y, led_r}, 13'b10);
        end

        // One illegal code then red: sticky fault, dashes, blinking red.
        tick(1'b1, 2'd0, 4'd0);
        tick(1'b0, 2'd3, 4'd10);
        for (int j = 1; j < 27; j++) begin
            tick(1'b0, 2'd2, 4'd10);
            check($sformatf("fault[%0d]", j), {3'd0, fault, seg, led_g, led_y, led_r},
                  {3'd0, 1'b1, 7'h40, 1'b0, 1'b0, ((j <= 9) || ((j >= 18) && (j <= 25)))});
        end

        // Mid-count reset clears everything including fault.
        tick(1'b0, 2'd2, 4'd7);
        tick(1'b1, 2'd2, 4'd7);
        check("midreset", dut_out(), {3'b000, 7'h00, 2'b01, 1'b0});
        tick(1'b0, 2'd2, 4'd7);
        check("post_reset", dut_out(), {3'b100, 7'h3F, 2'b01, 1'b0});

        // Random stimulus against the model.
        begin
            logic [1:0] s;
            logic [3:0] v;
            bit         r;
            s = 2'd0;
            v = 4'd0;
            for (int k = 0; k < 600; k++) begin
                r = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 11) == 0)
                    s = ($urandom_range(0, 39) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                if ($urandom_range(0, 3) == 0)
                    v = 4'($urandom_range(0, 15));
                tick(r, s, v);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
